gba_snes_pad_scanner: RTL and testbench

Serial-gamepad controller that feeds the joypad register block. It periodically sequences an SNES-style shift-register pad (LATCH/CLK/DATA), deserialises 16 bits, and maps them onto the ten active-high key inputs (KeyA..KeyL) consumed by the KEYINPUT/KEYCNT logic. It runs entirely in the `fclk` domain and owns all pad timing, disconnect detection and optional debounce.

---
 rtl/gba_snes_pad_scanner.sv | 204 ++++++++++++++++++++
 tb/tb_gba_snes_pad_scanner.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/gba_snes_pad_scanner.sv
// SNES serial pad scanner feeding the joypad key inputs.
// Define PAD_DEBOUNCE_EN to require two agreeing scans per key change.
`timescale 1ns/1ps
module gba_snes_pad_scanner #(
  parameter int CLK_DIV     = 6,
  parameter int POLL_PERIOD = 100000
) (
  input  logic fclk,
  input  logic rst,
  input  logic pad_data,
  output logic pad_latch,
  output logic pad_clk,
  output logic KeyA,
  output logic KeyB,
  output logic KeySelect,
  output logic KeyStart,
  output logic KeyRight,
  output logic KeyLeft,
  output logic KeyUp,
  output logic KeyDown,
  output logic KeyR,
  output logic KeyL,
  output logic pad_present,
  output logic scan_done
);

  localparam int PW = $clog2(POLL_PERIOD);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [8:0] LAT_LAST  = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_nxt;
  logic [PW-1:0]   r_poll;
  logic [8:0]      r_cnt;
  logic [3:0]      r_idx;
  logic [1:0]      r_sync;
  logic [15:0]     r_bits;
  logic [9:0]      r_keys;
  logic            r_latch;
  logic            r_clk;
  logic            r_present;
  logic            r_done;

  logic            w_wrap;
  logic            w_cnt_rst;
  logic            w_idx_clr;
  logic            w_idx_inc;
  logic            w_sample;
  logic            w_done;
  logic            w_absent;
  logic [9:0]      w_dec;

`ifdef PAD_DEBOUNCE_EN
  logic [9:0]      r_hist;
  logic            r_hvld;
  logic [9:0]      w_agree;
`endif

  assign w_wrap   = (r_poll == POLL_LAST);
  assign w_absent = (r_bits == 16'hFFFF);

  // key vector order: L R Down Up Left Right Start Select B A
  assign w_dec = {r_bits[10], r_bits[11], r_bits[5], r_bits[4],
                  r_bits[6], r_bits[7], r_bits[3], r_bits[2],
                  r_bits[0], r_bits[8]};

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    w_cnt_rst = 1'b0;
    w_idx_clr = 1'b0;
    w_idx_inc = 1'b0;
    w_sample  = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_wrap) begin
          w_nxt     = S_LATCH;
          w_cnt_rst = 1'b1;
        end
      end
      S_LATCH: begin
        if (r_cnt == LAT_LAST) begin
          w_nxt     = S_LOW;
          w_cnt_rst = 1'b1;
          w_idx_clr = 1'b1;
        end
      end
      S_LOW: begin
        if (r_cnt == HALF_LAST) begin
          w_nxt     = S_HIGH;
          w_cnt_rst = 1'b1;
          w_sample  = 1'b1;
        end
      end
      S_HIGH: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_rst = 1'b1;
          if (r_idx == 4'd15) begin
            w_nxt = S_DONE;
          end else begin
            w_nxt     = S_LOW;
            w_idx_inc = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_nxt  = S_IDLE;
        w_done = 1'b1;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      r_poll  <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sync  <= 2'b11;
      r_bits  <= '0;
      r_latch <= 1'b0;
      r_clk   <= 1'b1;
    end else begin
      r_poll  <= w_wrap ? '0 : r_poll + 1'b1;
      r_sync  <= {r_sync[0], pad_data};
      if (w_cnt_rst || r_state == S_IDLE) r_cnt <= '0;
      else                                r_cnt <= r_cnt + 1'b1;
      if (w_idx_clr)      r_idx <= '0;
      else if (w_idx_inc) r_idx <= r_idx + 1'b1;
      if (w_sample) r_bits[r_idx] <= ~r_sync[1];
      // pins follow the next state so they change on the state edge
      r_latch <= (w_nxt == S_LATCH);
      r_clk   <= (w_nxt != S_LOW);
    end
  end

`ifdef PAD_DEBOUNCE_EN
  assign w_agree = ~(w_dec ^ r_hist);
`endif

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      r_keys    <= '0;
      r_present <= 1'b0;
      r_done    <= 1'b0;
`ifdef PAD_DEBOUNCE_EN
      r_hist    <= '0;
      r_hvld    <= 1'b0;
`endif
    end else begin
      r_done <= w_done;
      if (w_done) begin
        if (w_absent) begin
          r_keys    <= '0;
          r_present <= 1'b0;
`ifdef PAD_DEBOUNCE_EN
          r_hist    <= '0;
          r_hvld    <= 1'b0;
`endif
        end else begin
          r_present <= 1'b1;
`ifdef PAD_DEBOUNCE_EN
          if (r_hvld)
            r_keys <= (w_agree & w_dec) | (~w_agree & r_keys);
          r_hist <= w_dec;
          r_hvld <= 1'b1;
`else
          r_keys <= w_dec;
`endif
        end
      end
    end
  end

  assign pad_latch   = r_latch;
  assign pad_clk     = r_clk;
  assign pad_present = r_present;
  assign scan_done   = r_done;
  assign KeyA        = r_keys[0];
  assign KeyB        = r_keys[1];
  assign KeySelect   = r_keys[2];
  assign KeyStart    = r_keys[3];
  assign KeyRight    = r_keys[4];
  assign KeyLeft     = r_keys[5];
  assign KeyUp       = r_keys[6];
  assign KeyDown     = r_keys[7];
  assign KeyR        = r_keys[8];
  assign KeyL        = r_keys[9];

endmodule

// File: tb/tb_gba_snes_pad_scanner.sv
// Directed bench for gba_snes_pad_scanner with a 4021-style pad model.
`timescale 1ns/1ps
module tb_gba_snes_pad_scanner;
  localparam int D = 4;
  localparam int P = 200;

  logic fclk = 1'b0;
  logic rst = 1'b1;
  logic tie0 = 1'b0;
  logic [15:0] raw = 16'hFFFF;
  logic [15:0] sr = 16'hFFFF;
  logic pad_data;
  logic pad_latch, pad_clk, pad_present, scan_done;
  logic KeyA, KeyB, KeySelect, KeyStart, KeyRight;
  logic KeyLeft, KeyUp, KeyDown, KeyR, KeyL;
  logic [9:0] keys;

  int checks = 0;
  int errors = 0;
  int tick = 0;
  int t_rel, t_lat, t_done, t_prev;
  int lat_c, lows, falls, len;

  gba_snes_pad_scanner #(.CLK_DIV(D), .POLL_PERIOD(P)) dut (
    .fclk(fclk), .rst(rst), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk),
    .KeyA(KeyA), .KeyB(KeyB), .KeySelect(KeySelect),
    .KeyStart(KeyStart), .KeyRight(KeyRight), .KeyLeft(KeyLeft),
    .KeyUp(KeyUp), .KeyDown(KeyDown), .KeyR(KeyR), .KeyL(KeyL),
    .pad_present(pad_present), .scan_done(scan_done)
  );

  always #5 fclk = ~fclk;
  always @(posedge fclk) tick <= tick + 1;

  always @(posedge pad_clk or posedge pad_latch) begin
    if (pad_latch) sr <= raw;
    else           sr <= {1'b1, sr[15:1]};
  end

  assign pad_data = tie0 ? 1'b0 : sr[0];
  assign keys = {KeyL, KeyR, KeyDown, KeyUp, KeyLeft,
                 KeyRight, KeyStart, KeySelect, KeyB, KeyA};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_scan();
    int n;
    logic pc;
    lat_c = 1; lows = 0; falls = 0; len = 0;
    n = 0;
    while (!pad_latch && n < 500) begin
      @(posedge fclk); #1; n++;
    end
    chk("latch_wait", 32'(n < 500), 1);
    t_lat = tick;
    pc = pad_clk;
    n = 0;
    while (!scan_done && n < 400) begin
      @(posedge fclk); #1; n++;
      if (pad_latch) lat_c++;
      if (!pad_clk) lows++;
      if (pc && !pad_clk) falls++;
      pc = pad_clk;
    end
    len = n;
    t_prev = t_done;
    t_done = tick;
  endtask

  task automatic done_low();
    @(posedge fclk); #1;
    chk("done_pulse", scan_done, 0);
  endtask

  initial begin
    int n;
    logic pc;
    t_done = 0;
    repeat (3) @(posedge fclk);
    #1;
    chk("rst_latch", pad_latch, 0);
    chk("rst_clk", pad_clk, 1);
    chk("rst_keys", keys, 0);
    chk("rst_present", pad_present, 0);
    chk("rst_done", scan_done, 0);

    raw = 16'hFEFF;
    @(negedge fclk);
    rst = 1'b0;
    t_rel = tick;
    run_scan();
    chk("first_start", t_lat - t_rel, P);
    chk("latch_len", lat_c, 2 * D);
    chk("clk_low_cyc", lows, 16 * D);
    chk("clk_falls", falls, 16);
    chk("scan_len", len, 34 * D + 1);
    chk("a_keys", keys, 10'h001);
    chk("a_present", pad_present, 1);
    done_low();

    tie0 = 1'b1;
    run_scan();
    chk("dis_keys", keys, 0);
    chk("dis_present", pad_present, 0);
    chk("dis_period", t_done - t_prev, P);
    done_low();

    tie0 = 1'b0;
    raw = 16'hFBF7;
    run_scan();
`ifdef PAD_DEBOUNCE_EN
    chk("sl1_keys", keys, 10'h000);
`else
    chk("sl1_keys", keys, 10'h208);
`endif
    chk("sl1_present", pad_present, 1);
    chk("sl1_period", t_done - t_prev, P);
    run_scan();
    chk("sl2_keys", keys, 10'h208);

    raw = 16'hFBFF;
    run_scan();
`ifdef PAD_DEBOUNCE_EN
    chk("rel1_keys", keys, 10'h208);
`else
    chk("rel1_keys", keys, 10'h200);
`endif
    run_scan();
    chk("rel2_keys", keys, 10'h200);
    chk("rel2_keyl", KeyL, 1);

    raw = 16'hFD0D;
    n = 0;
    while (!pad_latch && n < 500) begin
      @(posedge fclk); #1; n++;
    end
    pc = pad_clk;
    falls = 0;
    n = 0;
    while (falls < 8 && n < 300) begin
      @(posedge fclk); #1; n++;
      if (pc && !pad_clk) falls++;
      pc = pad_clk;
    end
    chk("mid_reach", falls, 8);
    chk("mid_clk_low", pad_clk, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_latch", pad_latch, 0);
    chk("mid_clk", pad_clk, 1);
    chk("mid_keys", keys, 0);
    chk("mid_present", pad_present, 0);
    repeat (2) @(posedge fclk);
    @(negedge fclk);
    rst = 1'b0;
    t_rel = tick;
    run_scan();
    chk("post_start", t_lat - t_rel, P);
    chk("post_present", pad_present, 1);
`ifdef PAD_DEBOUNCE_EN
    chk("dir1_keys", keys, 10'h000);
    run_scan();
`endif
    chk("dir_keys", keys, 10'h0F0);
    done_low();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
